// File: rtl/board_drop_engine.sv
`default_nettype none
// ============================================================================
// Module   : board_drop_engine
// Purpose  : 8x8 "drop a piece" game board. A request names a column and a
//            player. The engine scans upward from row 0 one row per cycle and
//            writes the player's code into the first empty cell it finds. It
//            reports the landing row, or it flags a full column. A separate
//            request empties the board one row per cycle.
// Ports    :
//   clk           in   1   sole clock, rising edge
//   rst_n         in   1   asynchronous active-low reset
//   drop_valid    in   1   drop request, held until accepted
//   drop_col      in   3   target column 0..7
//   drop_player   in   1   0 -> cell code 2'b01, 1 -> cell code 2'b10
//   drop_ready    out  1   request accepted on edge with drop_valid&drop_ready
//   clear_req     in   1   level request to empty the board
//   done          out  1   one-cycle pulse: piece placed
//   done_row      out  3   landing row, valid while done=1
//   col_full_err  out  1   one-cycle pulse: column full, drop rejected
//   piece_count   out  7   pieces on board, 0..64
//   board_full    out  1   piece_count == 64
//   disply_r_en   in   1   display read enable
//   display_addr  in   3   display row index
//   display_data  out  16  board row (combinational read)
// Revision : 1.0 - initial release
// ============================================================================
module board_drop_engine (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        drop_valid,
    input  logic [2:0]  drop_col,
    input  logic        drop_player,
    output logic        drop_ready,
    input  logic        clear_req,
    output logic        done,
    output logic [2:0]  done_row,
    output logic        col_full_err,
    output logic [6:0]  piece_count,
    output logic        board_full,
    input  logic        disply_r_en,
    input  logic [2:0]  display_addr,
    output logic [15:0] display_data
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SCAN  = 3'd1,
        DONE  = 3'd2,
        FULL  = 3'd3,
        CLEAR = 3'd4
    } state_t;

    localparam logic [6:0] MAX_PIECES = 7'd64;

    state_t      state_q, state_d;
    logic [2:0]  row_q, row_d;
    logic [2:0]  col_q, col_d;
    logic        player_q, player_d;
    logic        done_q, done_d;
    logic [2:0]  done_row_q, done_row_d;
    logic        full_err_q, full_err_d;
    logic [6:0]  count_q, count_d;
    logic [15:0] board_q [0:7];

    logic        wr_en;
    logic        clr_en;
    logic [3:0]  cell_lsb;
    logic [1:0]  cell_cur;
    logic [1:0]  player_code;

    // Column c lives in bits [2c+1:2c] of each row.
    assign cell_lsb    = {col_q, 1'b0};
    assign cell_cur    = board_q[row_q][cell_lsb +: 2];
    assign player_code = player_q ? 2'b10 : 2'b01;

    // ------------------------------------------------------------------
    // Next-state and datapath control
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        player_d   = player_q;
        count_d    = count_q;
        done_row_d = done_row_q;
        wr_en      = 1'b0;
        clr_en     = 1'b0;

        case (state_q)
            IDLE: begin
                // A clear request takes priority over a simultaneous drop.
                if (clear_req) begin
                    row_d   = 3'd0;
                    state_d = CLEAR;
                end else if (drop_valid) begin
                    col_d    = drop_col;
                    player_d = drop_player;
                    row_d    = 3'd0;
                    state_d  = SCAN;
                end
            end
            SCAN: begin
                // Scanning bottom-up guarantees every lower cell is occupied
                // when the first empty cell is written.
                if (cell_cur == 2'b00) begin
                    wr_en      = 1'b1;
                    done_row_d = row_q;
                    if (count_q < MAX_PIECES) begin
                        count_d = count_q + 7'd1;
                    end
                    state_d = DONE;
                end else if (row_q == 3'd7) begin
                    state_d = FULL;
                end else begin
                    row_d = row_q + 3'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            FULL: begin
                state_d = IDLE;
            end
            CLEAR: begin
                clr_en = 1'b1;
                row_d  = row_q + 3'd1;
                if (row_q == 3'd7) begin
                    count_d = 7'd0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Pulses are registered alongside the state that owns them.
        done_d     = (state_d == DONE);
        full_err_d = (state_d == FULL);
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            row_q      <= 3'd0;
            col_q      <= 3'd0;
            player_q   <= 1'b0;
            done_q     <= 1'b0;
            done_row_q <= 3'd0;
            full_err_q <= 1'b0;
            count_q    <= 7'd0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            player_q   <= player_d;
            done_q     <= done_d;
            done_row_q <= done_row_d;
            full_err_q <= full_err_d;
            count_q    <= count_d;
        end
    end

    // ------------------------------------------------------------------
    // Board storage: 8 rows x 16 bits, row 0 at the bottom
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 8; r++) begin
                board_q[r] <= 16'h0000;
            end
        end else if (clr_en) begin
            board_q[row_q] <= 16'h0000;
        end else if (wr_en) begin
            board_q[row_q][cell_lsb +: 2] <= player_code;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign drop_ready   = (state_q == IDLE) && !clear_req;
    assign done         = done_q;
    assign done_row     = done_row_q;
    assign col_full_err = full_err_q;
    assign piece_count  = count_q;
    assign board_full   = (count_q == MAX_PIECES);

    // Read port sees the registered board, so a write lands only after its edge.
    assign display_data = disply_r_en ? board_q[display_addr] : 16'h0000;

endmodule
`default_nettype wire

// File: tb/tb_board_drop_engine.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_board_drop_engine
// Purpose  : Self-checking bench for board_drop_engine. Every drop pushes its
//            expected outcome (landing row or column-full, and the cycle the
//            pulse is due) onto a scoreboard. A monitor pops it when the DUT
//            pulses. A reference board model supplies the expected display rows.
// Revision : 1.0 - initial release
// ============================================================================
module tb_board_drop_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        drop_valid;
    logic [2:0]  drop_col;
    logic        drop_player;
    logic        drop_ready;
    logic        clear_req;
    logic        done;
    logic [2:0]  done_row;
    logic        col_full_err;
    logic [6:0]  piece_count;
    logic        board_full;
    logic        disply_r_en;
    logic [2:0]  display_addr;
    logic [15:0] display_data;

    board_drop_engine dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .drop_valid   (drop_valid),
        .drop_col     (drop_col),
        .drop_player  (drop_player),
        .drop_ready   (drop_ready),
        .clear_req    (clear_req),
        .done         (done),
        .done_row     (done_row),
        .col_full_err (col_full_err),
        .piece_count  (piece_count),
        .board_full   (board_full),
        .disply_r_en  (disply_r_en),
        .display_addr (display_addr),
        .display_data (display_data)
    );

    always #20 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic       is_full;
        logic [2:0] row;
        int         due;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_chk  = 0;
    int          n_pass = 0;
    logic [15:0] mb [8];
    int          h [8];
    int          mcount;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int r = 0; r < 8; r++) begin
            mb[r] = 16'h0000;
            h[r]  = 0;
        end
        mcount = 0;
    endtask

    // Scoreboard consumer: every pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && (done || col_full_err)) begin
            if (sb.size() == 0) begin
                chk("unexpected_pulse", {30'd0, done, col_full_err}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("pulse_kind", col_full_err, mon_e.is_full);
                chk("done_flag", done, !mon_e.is_full);
                if (!mon_e.is_full) chk("done_row", done_row, mon_e.row);
                chk("latency", cyc, mon_e.due);
            end
        end
    end

    task automatic check_board(input string tag);
        disply_r_en = 1'b1;
        for (int r = 0; r < 8; r++) begin
            display_addr = r[2:0];
            #1;
            chk(tag, display_data, mb[r]);
        end
        disply_r_en = 1'b0;
    endtask

    task automatic do_drop(input logic [2:0] c, input logic p);
        int   waited;
        int   ci;
        exp_t e;
        ci = int'(c);
        @(negedge clk);
        drop_valid  = 1'b1;
        drop_col    = c;
        drop_player = p;
        #1;
        waited = 0;
        while (!drop_ready && waited < 50) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!drop_ready) begin
            chk("accept_timeout", 0, 1);
            drop_valid = 1'b0;
            return;
        end
        // Acceptance is the next posedge (edge 0); landing row r pulses after edge r+1.
        if (h[ci] < 8) begin
            e.is_full = 1'b0;
            e.row     = h[ci][2:0];
            e.due     = cyc + h[ci] + 2;
            mb[h[ci]][2*ci +: 2] = p ? 2'b10 : 2'b01;
            h[ci]++;
            if (mcount < 64) mcount++;
        end else begin
            e.is_full = 1'b1;
            e.row     = 3'd0;
            e.due     = cyc + 9;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        // Perturb the request inputs; the operation in flight must not notice.
        drop_valid  = 1'b0;
        drop_col    = ~c;
        drop_player = ~p;
        waited = 0;
        while (sb.size() != 0 && waited < 30) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (sb.size() != 0) begin
            chk("pulse_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic do_clear_with_drop();
        int n;
        @(negedge clk);
        clear_req   = 1'b1;
        drop_valid  = 1'b1;
        drop_col    = 3'd2;
        drop_player = 1'b0;
        #1;
        chk("ready_with_clear_req", drop_ready, 0);
        @(posedge clk);
        #1;
        clear_req  = 1'b0;
        drop_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!drop_ready && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("clear_cycles", n, 8);
        model_reset();
    endtask

    initial begin
        logic p;
        rst_n        = 1'b0;
        drop_valid   = 1'b0;
        drop_col     = 3'd0;
        drop_player  = 1'b0;
        clear_req    = 1'b0;
        disply_r_en  = 1'b0;
        display_addr = 3'd0;
        model_reset();

        repeat (2) @(negedge clk);
        chk("rst_done", done, 0);
        chk("rst_full_err", col_full_err, 0);
        chk("rst_count", piece_count, 0);
        chk("rst_board_full", board_full, 0);
        chk("rst_done_row", done_row, 0);
        check_board("rst_row");
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("ready_after_reset", drop_ready, 1);

        // Stack column 3 until full.
        do_drop(3'd3, 1'b0);
        check_board("drop1_row");
        chk("drop1_count", piece_count, 1);
        do_drop(3'd3, 1'b1);
        check_board("drop2_row");
        chk("drop2_count", piece_count, 2);
        for (int k = 0; k < 6; k++) do_drop(3'd3, k[0]);
        chk("col3_count", piece_count, 8);
        do_drop(3'd3, 1'b0);
        check_board("col_full_row");
        chk("col_full_count", piece_count, 8);

        // Clear beats a simultaneous drop.
        do_clear_with_drop();
        check_board("clear_row");
        chk("clear_count", piece_count, 0);
        do_drop(3'd0, 1'b1);
        chk("after_clear_count", piece_count, 1);
        check_board("after_clear_row");

        // Fill every cell.
        for (int c = 0; c < 8; c++) begin
            while (h[c] < 8) begin
                p = 1'($urandom_range(0, 1));
                do_drop(c[2:0], p);
            end
        end
        chk("fill_board_full", board_full, 1);
        chk("fill_count", piece_count, 64);
        check_board("fill_row");
        disply_r_en = 1'b1;
        for (int r = 0; r < 8; r++) begin
            display_addr = r[2:0];
            #1;
            chk("fill_row_nonzero", display_data != 16'h0000, 1);
        end
        disply_r_en = 1'b0;
        #1;
        chk("display_disabled", display_data, 0);
        do_drop(3'd7, 1'b0);
        chk("sat_count", piece_count, 64);

        // Reset in the middle of a scan of row 4.
        do_clear_with_drop();
        for (int k = 0; k < 4; k++) do_drop(3'd5, 1'b1);
        check_board("col5_row");
        @(negedge clk);
        drop_valid  = 1'b1;
        drop_col    = 3'd5;
        drop_player = 1'b0;
        #1;
        chk("ready_before_scan", drop_ready, 1);
        @(posedge clk);
        #1;
        drop_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        chk("async_rst_count", piece_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (12) @(negedge clk);
        #1;
        chk("ready_after_abort", drop_ready, 1);
        chk("done_after_abort", done, 0);
        check_board("abort_row");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
